mod_exp_mont: RTL and testbench
===============================

// Module: mod_exp_mont
// PURPOSE
//  - Modular exponentiator: R = M^E mod N, using Montgomery multiplication.
//  - Uses a bit-serial Montgomery multiplier and left-to-right square-and-multiply.
//  - Standalone arithmetic core for the RSA datapath.
//  - Host supplies operands and the Montgomery constant C, pulses start1, then reads R when done fires.
// PARAMETERS
//  - WIDTH  32  Operand width in bits (M, E, N, C, R).
//  - K   WIDTH+3  Montgomery radix exponent; derived localparam, not overridable.
// PORTS
//  - clk     in   1      Single clock; all logic on rising edge.
//  - rst_n   in   1      Reset, synchronous and active-low.
//  - start1  in   1      Start request; rising edge while idle launches a computation.
//  - M       in   WIDTH  Base; any value < 2^WIDTH, reduced implicitly.
//  - E       in   WIDTH  Exponent.
//  - N       in   WIDTH  Modulus; must be odd.
//  - C       in   WIDTH  Montgomery constant, 2^(2K) mod N (N=29 -> C=28).
//  - R       out  WIDTH  Result register; holds the last completed result.
//  - done    out  1      One-cycle pulse when R is updated.
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): state=IDLE, R=0, done=0, start1 edge register=0.
//  - Reset mid-operation: abort immediately to the reset state.
//  - Start detection: start1=1 and registered previous start1=0, in IDLE.
//    - A start1 held high from reset release counts as a rising edge.
//    - Starts while busy are ignored.
//  - Capture: M, E, N, C are latched on the accepted start; later input changes are ignored until done.
//  - MonMul(A,B):
//    - S=0; repeat K times, i=0..K-1: S += A[i]*B; if S odd then S += N; S >>= 1.
//    - Final step: if S>=N then S -= N.
//    - A is zero-extended to K bits; S is WIDTH+2 bits wide; result is < N.
//    - Cost: K+1 cycles, one cycle per iteration plus one cycle for the conditional subtract.
//  - States:
//    - IDLE -> PRE1: Mb = MonMul(M,C).
//    - PRE1 -> PRE2: Xb = MonMul(1,C).
//    - PRE2 -> LOOP over E bits WIDTH-1 down to 0: Xb = MonMul(Xb,Xb), then Pm = MonMul(Xb,Mb).
//      - Commit Xb = Pm only if E[bit]=1; the multiply always runs, giving constant time.
//    - LOOP -> POST: R_next = MonMul(Xb,1).
//    - POST -> DONE: load R, pulse done for one cycle.
//    - DONE -> IDLE.
//  - Latency: fixed (2*WIDTH+3)*(K+1)+1 cycles from accepted start to done; 2413 cycles for WIDTH=32.
//  - Boundary cases:
//    - E=0 -> R = 1 mod N (0 if N=1).
//    - M=0 with E>0 -> R=0.
//    - M>=N is handled correctly.
//  - Invalid modulus: N even (including N=0) is detected at start; the normal latency still runs, then R=0.
//  - R changes only in the done cycle.
// CONFIGURATION
//  - MME_LZ_SKIP_EN defined:
//    - During PRE1/PRE2 a priority encoder finds the MSB of E; LOOP starts at that bit.
//    - Latency becomes (2*(msb+1)+3)*(K+1)+1; for E=0, 3*(K+1)+1.
//  - MME_LZ_SKIP_EN undefined: the loop always scans all WIDTH bits at the fixed latency above.
// TESTING
//  - Case 1: rst_n low 2 cycles then high, start1=1 held; M=23, E=31, N=29, C=28.
//    - Expect one done pulse, R=16, then R stays 16 (no re-launch while start1 stays high).
//  - Case 2: M=4, E=13, N=497, C=2^70 mod 497 -> R=445.
//    - Check done latency is exactly 2413 cycles (without MME_LZ_SKIP_EN).
//  - Case 3: M=23, E=0, N=29, C=28 -> R=1.
//  - Case 4: M=0, E=5, N=29, C=28 -> R=0.
//  - Case 5: M=52, E=31, N=29, C=28 -> R=16.
//  - Case 6: mid-run stimulus.
//    - Toggle start1 and change M mid-run: result unchanged.
//    - Assert rst_n=0 mid-run: next cycle R=0, done=0, state IDLE.

Source files
------------

// File: rtl/mod_exp_mont.sv
// -----------------------------------------------------------------------------
// mod_exp_mont
//   Modular exponentiator R = M^E mod N. It uses a bit-serial Montgomery
//   multiplier with radix 2^K (K = WIDTH+3) and left-to-right square-and-multiply.
//   The host presents M, E, N and C = 2^(2K) mod N, raises start1, and then
//   reads R when done pulses.
//
//   Optional feature macro: MME_LZ_SKIP_EN
//     When it is defined, the exponent loop starts at the MSB of E instead of
//     at bit WIDTH-1. When E = 0, the loop is skipped entirely.
//
// Ports
//   clk     in   1      rising-edge clock
//   rst_n   in   1      synchronous active-low reset
//   start1  in   1      start request; a rising edge while idle launches a run
//   M       in   WIDTH  base (any value; reduced implicitly)
//   E       in   WIDTH  exponent
//   N       in   WIDTH  modulus (must be odd; even N gives R = 0)
//   C       in   WIDTH  Montgomery constant 2^(2K) mod N
//   R       out  WIDTH  last completed result
//   done    out  1      one-cycle pulse when R is updated
// -----------------------------------------------------------------------------
module mod_exp_mont #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start1,
    input  logic [WIDTH-1:0] M,
    input  logic [WIDTH-1:0] E,
    input  logic [WIDTH-1:0] N,
    input  logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] R,
    output logic             done
);

    localparam int K  = WIDTH + 3;          // Montgomery radix exponent
    localparam int SW = WIDTH + 2;          // accumulator width; S < 2N always
    localparam int CW = $clog2(K + 1);      // iteration counter width
    localparam int BW = $clog2(WIDTH);      // exponent bit index width

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE1,     // Mb = MonMul(M, C)
        S_PRE2,     // Xb = MonMul(1, C)
        S_SQR,      // Xb = MonMul(Xb, Xb)
        S_MUL,      // Pm = MonMul(Xb, Mb), committed only when E[bit] = 1
        S_POST,     // leave Montgomery domain: MonMul(Xb, 1)
        S_DONE
    } state_t;

    state_t             state_q;
    logic               start_prev_q;
    logic [WIDTH-1:0]   r_q;
    logic               done_q;

    // Captured operands and intermediate values.
    logic [WIDTH-1:0]   e_q, n_q, c_q;
    logic               bad_q;          // modulus was even at start
    logic [WIDTH-1:0]   mb_q, xb_q;
    logic [BW-1:0]      bit_q;

    // Montgomery multiplier state: a_q shifts right once per iteration.
    logic [WIDTH-1:0]   a_q, b_q;
    logic [SW-1:0]      s_q;
    logic [CW-1:0]      cnt_q;

    // Combinational multiplier step.
    logic [SW-1:0]      s_add, s_red, s_d;
    logic [WIDTH-1:0]   mm_res, xb_sel;
    logic               mm_last;

    always_comb begin
        s_add   = s_q + (a_q[0] ? {2'b00, b_q} : {SW{1'b0}});
        s_red   = s_add[0] ? s_add + {2'b00, n_q} : s_add;
        s_d     = s_red >> 1;
        // The final conditional subtract brings S from [0, 2N) into [0, N).
        mm_res  = (s_q >= {2'b00, n_q}) ? WIDTH'(s_q - {2'b00, n_q}) : s_q[WIDTH-1:0];
        mm_last = (cnt_q == CW'(K));
        // The multiply in S_MUL always runs, so the time is constant.
        // Only the commit depends on the exponent bit.
        xb_sel  = e_q[bit_q] ? mm_res : xb_q;
    end

`ifdef MME_LZ_SKIP_EN
    // Priority encoder: index of the highest set bit of the captured exponent.
    logic [BW-1:0] e_msb;
    always_comb begin
        e_msb = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (e_q[i]) e_msb = BW'(i);
        end
    end
`endif

    assign R    = r_q;
    assign done = done_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: only control state and outputs are reset. The datapath
            // registers are always loaded before they are read, so resetting
            // them would only add reset fan-out.
            state_q      <= S_IDLE;
            start_prev_q <= 1'b0;
            r_q          <= '0;
            done_q       <= 1'b0;
        end else begin
            start_prev_q <= start1;
            done_q       <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start1 && !start_prev_q) begin
                        e_q     <= E;
                        n_q     <= N;
                        c_q     <= C;
                        bad_q   <= ~N[0];
                        bit_q   <= BW'(WIDTH - 1);
                        a_q     <= M;
                        b_q     <= C;
                        s_q     <= '0;
                        cnt_q   <= '0;
                        state_q <= S_PRE1;
                    end
                end

                S_DONE: begin
                    r_q     <= bad_q ? '0 : xb_q;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end

                default: begin
                    if (!mm_last) begin
                        // One Montgomery iteration per cycle.
                        s_q   <= s_d;
                        a_q   <= a_q >> 1;
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        // This multiply finished. Store its result and load the next one.
                        s_q   <= '0;
                        cnt_q <= '0;
                        case (state_q)
                            S_PRE1: begin
                                mb_q    <= mm_res;
                                a_q     <= WIDTH'(1);
                                b_q     <= c_q;
                                state_q <= S_PRE2;
                            end
                            S_PRE2: begin
                                xb_q <= mm_res;
                                a_q  <= mm_res;
`ifdef MME_LZ_SKIP_EN
                                if (e_q == '0) begin
                                    b_q     <= WIDTH'(1);
                                    state_q <= S_POST;
                                end else begin
                                    bit_q   <= e_msb;
                                    b_q     <= mm_res;
                                    state_q <= S_SQR;
                                end
`else
                                b_q     <= mm_res;
                                state_q <= S_SQR;
`endif
                            end
                            S_SQR: begin
                                xb_q    <= mm_res;
                                a_q     <= mm_res;
                                b_q     <= mb_q;
                                state_q <= S_MUL;
                            end
                            S_MUL: begin
                                xb_q <= xb_sel;
                                a_q  <= xb_sel;
                                if (bit_q == '0) begin
                                    b_q     <= WIDTH'(1);
                                    state_q <= S_POST;
                                end else begin
                                    b_q     <= xb_sel;
                                    bit_q   <= bit_q - 1'b1;
                                    state_q <= S_SQR;
                                end
                            end
                            S_POST: begin
                                xb_q    <= mm_res;
                                state_q <= S_DONE;
                            end
                            default: state_q <= S_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_exp_mont.sv
// -----------------------------------------------------------------------------
// tb_mod_exp_mont
//   Directed bench for mod_exp_mont in its default build (full-width exponent
//   scan). The expected results were worked out by hand:
//     23^31 mod 29 = 16        4^13 mod 497 = 445 (C = 2^70 mod 497 = 72)
//     23^0  mod 29 = 1         0^5 mod 29 = 0     52^31 mod 29 = 16
//   The latency from the start-accept edge to the done pulse is
//   67*36 + 1 = 2413 cycles.
// -----------------------------------------------------------------------------
module tb_mod_exp_mont;

    localparam int LAT    = 2413;
    localparam int BUDGET = 3000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start1;
    logic [31:0] M, E, N, C;
    logic [31:0] R;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    mod_exp_mont dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start1 (start1),
        .M      (M),
        .E      (E),
        .N      (N),
        .C      (C),
        .R      (R),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Counts edges after the accept edge until done is seen (bounded).
    task automatic wait_done(output int cyc, output logic ok);
        cyc = 0;
        ok  = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Holds start1 low for one edge, then raises it for the accept edge.
    task automatic launch(input logic [31:0] m, e, n, c);
        M = m; E = e; N = n; C = c;
        start1 = 1'b0;
        @(posedge clk); #1;
        start1 = 1'b1;
        @(posedge clk); #1;         // accept edge
        start1 = 1'b0;
    endtask

    task automatic run_case(input string tag, input logic [31:0] m, e, n, c,
                            input logic [31:0] exp_r);
        int   cyc;
        logic ok;
        launch(m, e, n, c);
        wait_done(cyc, ok);
        check({tag, "_done_seen"}, 32'(ok), 32'd1);
        check({tag, "_R"}, R, exp_r);
        check({tag, "_latency"}, cyc, LAT);
    endtask

    // Counts done pulses over a window; used to prove nothing launches.
    task automatic count_pulses(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
    endtask

    initial begin
        int   cyc;
        int   pulses;
        logic ok;

        // Case 1: reset with start1 already high; release counts as an edge.
        rst_n = 1'b0; start1 = 1'b1;
        M = 32'd23; E = 32'd31; N = 32'd29; C = 32'd28;
        repeat (2) @(posedge clk);
        #1;
        check("rst_R", R, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;         // accept edge
        wait_done(cyc, ok);
        check("c1_done_seen", 32'(ok), 32'd1);
        check("c1_R", R, 32'd16);
        check("c1_latency", cyc, LAT);
        @(posedge clk); #1;
        check("c1_done_one_cycle", 32'(done), 32'd0);
        count_pulses(LAT + 100, pulses);
        check("c1_no_relaunch", pulses, 32'd0);
        check("c1_R_held", R, 32'd16);

        // Case 2: larger modulus; the latency is checked exactly.
        run_case("c2", 32'd4, 32'd13, 32'd497, 32'd72, 32'd445);
        // Case 3: E = 0 gives 1 mod N.
        run_case("c3", 32'd23, 32'd0, 32'd29, 32'd28, 32'd1);
        // E = 0 with N = 1 gives 0 (C = 2^70 mod 1 = 0).
        run_case("n1", 32'd23, 32'd0, 32'd1, 32'd0, 32'd0);
        // Case 5: M >= N.
        run_case("c5", 32'd52, 32'd31, 32'd29, 32'd28, 32'd16);
        // Case 4: M = 0 with E > 0.
        run_case("c4", 32'd0, 32'd5, 32'd29, 32'd28, 32'd0);

        // Case 6a: input and start1 activity mid-run must not disturb the run.
        launch(32'd23, 32'd31, 32'd29, 32'd28);
        cyc = 0;
        ok  = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            if (i == 100) begin start1 = 1'b1; M = 32'd5; E = 32'd3; end
            if (i == 101) start1 = 1'b0;
            if (i == 200) begin N = 32'd7; C = 32'd1; end
            @(posedge clk); #1;
            cyc++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check("c6_done_seen", 32'(ok), 32'd1);
        check("c6_R", R, 32'd16);
        check("c6_latency", cyc, LAT);

        // Case 6b: reset mid-run aborts and clears R and done.
        launch(32'd4, 32'd13, 32'd497, 32'd72);
        repeat (1000) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_R", R, 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        count_pulses(LAT + 100, pulses);
        check("rst_mid_aborted", pulses, 32'd0);

        // Recovery after the abort, then an invalid (even) modulus.
        run_case("recover", 32'd52, 32'd31, 32'd29, 32'd28, 32'd16);
        run_case("n_even", 32'd23, 32'd31, 32'd28, 32'd28, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
